dm_arbiter: RTL
===============

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning:
  clk  in  1  sole clock; all state updates on its rising edge.
  reset  in  1  synchronous, active-high reset, sampled on rising clk.
  c_req  in  1  CPU port request, single access.
  c_we  in  1  CPU write (1) / read (0).
  c_size  in  2  00 word, 01 half, 10 byte; 11 treated as byte.
  c_addr  in  32  CPU byte address.
  c_wdata  in  32  CPU store data, right-aligned (low bits valid).
  c_gnt  out  1  CPU request accepted this cycle.
  c_rvalid  out  1  CPU read data valid.
  c_rdata  out  32  CPU load data, sign-extended.
  c_err  out  1  one-cycle pulse: CPU access misaligned, dropped.
  d_req  in  1  DMA port request, word burst.
  d_we  in  1  DMA burst write (1) / read (0).
  d_len  in  4  burst length minus one (1..16 words).
  d_addr  in  32  DMA burst start address, word aligned.
  d_wdata  in  32  DMA write data for the current beat.
  d_gnt  out  1  DMA beat accepted this cycle.
  d_rvalid  out  1  DMA read beat valid.
  d_rdata  out  32  DMA read beat data.
  d_done  out  1  one-cycle pulse on last accepted DMA beat.
  m_we  out  1  memory write strobe.
  m_be  out  4  memory byte enables.
  m_addr  out  32  memory byte address, bits [1:0] forced 00.
  m_wdata  out  32  lane-aligned write data.
  m_rdata  in  32  memory word read, combinational from m_addr.
REQ-002 The block SHALL have no parameters.

Function
REQ-003 FSM states: IDLE, BURST.
REQ-004 In IDLE, a single access SHALL be accepted per cycle. With exactly one of c_req or d_req high, that requester SHALL win. With both high, the winner SHALL be the port not granted most recently (round-robin pointer last_dma, reset 0, so the CPU wins first).
REQ-005 CPU grant: c_gnt=1 combinationally in the same cycle. m_addr, m_we, m_be and m_wdata SHALL be driven that cycle, and the FSM SHALL stay in IDLE.
REQ-006 Write lanes: word gives be=1111 and data unchanged. Half gives be=0011 (addr[1]=0) or 1100 (addr[1]=1) and data {2{wdata[15:0]}}. Byte gives be one-hot at addr[1:0] and data {4{wdata[7:0]}}.
REQ-007 Misaligned means half with addr[0]=1, or word with addr[1:0]!=00. A misaligned CPU access SHALL be granted, with m_we=0 and m_be=0000, c_err pulsed in the next cycle, and no c_rvalid.
REQ-008 CPU read: c_rdata SHALL be registered and presented with c_rvalid=1 exactly one cycle after c_gnt. Data SHALL be the selected halfword or byte of m_rdata, sign-extended, using the same lane selection as REQ-006.
REQ-009 DMA grant in IDLE: latch d_addr into a beat address register and d_len into a remaining-beat counter. Beat 0 SHALL be issued that cycle with d_gnt=1. If d_len=0, assert d_done that cycle and stay in IDLE; otherwise go to BURST.
REQ-010 In BURST, one beat SHALL be issued per cycle with d_gnt=1, address +4 per beat (32-bit wrap, no carry-out), and counter -1 per beat. The beat with counter=0 SHALL assert d_done and return to IDLE.
REQ-011 In BURST, c_req SHALL be ignored (c_gnt=0) and last_dma SHALL be set, so a pending CPU request wins the first IDLE cycle after the burst.
REQ-012 DMA beats SHALL always use be=1111 and m_we=d_we. d_addr[1:0] SHALL be ignored.
REQ-013 DMA read: d_rdata and d_rvalid SHALL be registered, one cycle after each read beat's d_gnt.
REQ-014 A requester SHALL hold req and its fields stable until gnt. The arbiter SHALL not latch the CPU fields.
REQ-015 With no grant in a cycle, m_we=0, m_be=0000, m_addr=0 and m_wdata=0.

Reset
REQ-016 On reset: state=IDLE, last_dma=0, counter=0, beat address=0, and c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_done, m_we all 0. c_rdata, d_rdata and m_be SHALL be 0.
REQ-017 Reset asserted mid-burst SHALL abort the burst at once: no further beats, no d_done, and memory contents already written are unchanged.

Verification
REQ-018 CPU sb with addr=0x0000_0003 and wdata=0x0000_00AB gives that same cycle m_be=1000, m_wdata=0xABABABAB, m_we=1.
REQ-019 CPU lh at addr 0x2 with m_rdata=0x8001_1234 gives, next cycle, c_rvalid=1 and c_rdata=0xFFFF_8001.
REQ-020 c_req and d_req both high from reset: the CPU is granted cycle 0, the DMA cycle 1, the CPU again on the first IDLE cycle after the burst.
REQ-021 DMA write with d_len=3 at 0x100 gives 4 consecutive d_gnt cycles with m_addr 0x100, 0x104, 0x108, 0x10C, and d_done with the 4th beat. c_gnt stays 0 throughout.
REQ-022 CPU sw at 0x6 gives m_we=0 and m_be=0000, and c_err=1 next cycle.
REQ-023 reset asserted in beat 2 of a 16-beat burst gives m_we=0 and state IDLE next cycle, and d_done is never seen.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-port memory arbiter: a CPU port doing single sized accesses and a DMA port doing word bursts.
// Both ports share one combinational-read, byte-enabled memory.
module dm_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [1:0]  c_size,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_len,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e      state_q;
  logic        last_dma_q;
  logic        granted_q;
  logic        we_q;
  logic [3:0]  cnt_q;
  logic [31:0] baddr_q;
  logic        c_rvalid_q, c_err_q, d_rvalid_q;
  logic [31:0] c_rdata_q, d_rdata_q;

  logic        cpu_win, dma_start, burst_beat;
  logic        cpu_mis, cpu_rd, dma_rd;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata, c_rdata_d;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;

  // Size decode: lane enables, replicated store data and sign-extended load data.
  always_comb begin
    cpu_mis   = 1'b0;
    cpu_be    = 4'h0;
    cpu_wdata = '0;
    c_rdata_d = '0;
    rd_half   = c_addr[1] ? m_rdata[31:16] : m_rdata[15:0];
    rd_byte   = m_rdata[{c_addr[1:0], 3'b000} +: 8];
    case (c_size)
      2'b00: begin
        cpu_mis   = |c_addr[1:0];
        cpu_be    = 4'hF;
        cpu_wdata = c_wdata;
        c_rdata_d = m_rdata;
      end
      2'b01: begin
        cpu_mis   = c_addr[0];
        cpu_be    = c_addr[1] ? 4'b1100 : 4'b0011;
        cpu_wdata = {2{c_wdata[15:0]}};
        c_rdata_d = {{16{rd_half[15]}}, rd_half};
      end
      default: begin
        cpu_be    = 4'b0001 << c_addr[1:0];
        cpu_wdata = {4{c_wdata[7:0]}};
        c_rdata_d = {{24{rd_byte[7]}}, rd_byte};
      end
    endcase
  end

  // The CPU wins a tie before any grant, and afterwards whenever the DMA was served last.
  assign cpu_win    = !reset && (state_q == IDLE) && c_req &&
                      (!d_req || !granted_q || last_dma_q);
  assign dma_start  = !reset && (state_q == IDLE) && d_req && !cpu_win;
  assign burst_beat = !reset && (state_q == BURST);
  assign cpu_rd     = cpu_win && !cpu_mis && !c_we;
  assign dma_rd     = (dma_start && !d_we) || (burst_beat && !we_q);

  assign c_gnt    = cpu_win;
  assign d_gnt    = dma_start || burst_beat;
  assign d_done   = (dma_start && (d_len == 4'd0)) || (burst_beat && (cnt_q == 4'd0));
  assign c_rvalid = c_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign c_err    = c_err_q;
  assign d_rvalid = d_rvalid_q;
  assign d_rdata  = d_rdata_q;

  always_comb begin
    m_we    = 1'b0;
    m_be    = 4'h0;
    m_addr  = '0;
    m_wdata = '0;
    if (cpu_win) begin
      m_addr = {c_addr[31:2], 2'b00};
      if (!cpu_mis) begin
        m_we    = c_we;
        m_be    = cpu_be;
        m_wdata = cpu_wdata;
      end
    end else if (dma_start) begin
      m_addr  = {d_addr[31:2], 2'b00};
      m_we    = d_we;
      m_be    = 4'hF;
      m_wdata = d_wdata;
    end else if (burst_beat) begin
      m_addr  = baddr_q;
      m_we    = we_q;
      m_be    = 4'hF;
      m_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_dma_q <= 1'b0;
      granted_q  <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= 4'd0;
      baddr_q    <= '0;
      c_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      c_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      c_rvalid_q <= cpu_rd;
      c_err_q    <= cpu_win && cpu_mis;
      d_rvalid_q <= dma_rd;
      if (cpu_rd) c_rdata_q <= c_rdata_d;
      if (dma_rd) d_rdata_q <= m_rdata;
      case (state_q)
        IDLE: begin
          if (cpu_win) begin
            last_dma_q <= 1'b0;
            granted_q  <= 1'b1;
          end else if (dma_start) begin
            last_dma_q <= 1'b1;
            granted_q  <= 1'b1;
            if (d_len != 4'd0) begin
              // Beat 0 goes out now; the counter holds beats still to come, minus one.
              we_q    <= d_we;
              baddr_q <= {d_addr[31:2], 2'b00} + 32'd4;
              cnt_q   <= d_len - 4'd1;
              state_q <= BURST;
            end
          end
        end
        BURST: begin
          last_dma_q <= 1'b1;
          baddr_q    <= baddr_q + 32'd4;
          if (cnt_q == 4'd0) state_q <= IDLE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
